// File: rtl/soda_pkg.sv
// Shared types and widths for the soda dispenser controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package soda_pkg;

    localparam int AMT_W = 8;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        WAIT = 2'd1,
        ADD  = 2'd2,
        DISP = 2'd3
    } soda_state_t;

endpackage

// File: rtl/soda_dispenser.sv
// Single-product vend controller: accumulates coin values and vends once the total reaches the live price.
// Latency: coin sampled in WAIT is added one edge later; vend strobe follows one edge after that.
// Backpressure: none; coins strobed outside WAIT are dropped, so upstream spaces coin pulses apart.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   c    coin-inserted strobe, one cycle per coin
//   s    price in cents, compared live every WAIT cycle
//   a    coin value in cents, valid while c is high
//   d    dispense strobe, one cycle per vend (Moore, high only in DISP)
module soda_dispenser
    import soda_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             c,
    input  logic [AMT_W-1:0] s,
    input  logic [AMT_W-1:0] a,
    output logic             d
);

    soda_state_t      state;
    soda_state_t      state_nxt;
    logic [AMT_W-1:0] tot;
    logic [AMT_W-1:0] tot_nxt;
    logic [AMT_W-1:0] coin;
    logic [AMT_W-1:0] coin_nxt;
    logic [AMT_W:0]   sum;

    // One extra bit catches overflow so the total pins at full scale instead of wrapping.
    assign sum = {1'b0, tot} + {1'b0, coin};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            tot   <= '0;
            coin  <= '0;
        end else begin
            state <= state_nxt;
            tot   <= tot_nxt;
            coin  <= coin_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tot_nxt   = tot;
        coin_nxt  = coin;
        case (state)
            INIT: begin
                // Excess over the price is discarded here; no change is given.
                tot_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A fresh coin wins over vending so its value counts before the compare.
                if (c) begin
                    coin_nxt  = a;
                    state_nxt = ADD;
                end else if (tot >= s) begin
                    state_nxt = DISP;
                end
            end
            ADD: begin
                tot_nxt   = sum[AMT_W] ? {AMT_W{1'b1}} : sum[AMT_W-1:0];
                state_nxt = WAIT;
            end
            DISP: begin
                state_nxt = INIT;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign d = (state == DISP);

endmodule

// File: tb/tb_soda_dispenser.sv
module tb_soda_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       c   = 1'b0;
    logic [7:0] s   = 8'd60;
    logic [7:0] a   = 8'd0;
    logic       d;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a total, plus how many cycles the controller stays deaf
    // after an event, and what must happen to the total when that busy time elapses.
    int  m_tot   = 0;
    int  m_busy  = 0;
    int  m_add   = -1;   // coin value waiting to be credited, -1 when none
    bit  m_clear = 1'b0; // total is wiped when the busy time runs out
    bit  m_d     = 1'b0;
    int  vends   = 0;

    soda_dispenser dut (
        .clk (clk),
        .rst (rst),
        .c   (c),
        .s   (s),
        .a   (a),
        .d   (d)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (rst) begin
            m_tot   = 0;
            m_busy  = 1;
            m_add   = -1;
            m_clear = 1'b0;
            m_d     = 1'b0;
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
            m_d    = 1'b0;
            if (m_add >= 0) begin
                m_tot = (m_tot + m_add > 255) ? 255 : m_tot + m_add;
                m_add = -1;
            end
            if (m_busy == 0 && m_clear) begin
                m_tot   = 0;
                m_clear = 1'b0;
            end
        end else if (c) begin
            m_add  = int'(a);
            m_busy = 1;
            m_d    = 1'b0;
        end else if (m_tot >= int'(s)) begin
            // One vend cycle, then a clearing cycle before the next coin is heard.
            m_d     = 1'b1;
            m_busy  = 2;
            m_clear = 1'b1;
        end else begin
            m_d = 1'b0;
        end
    endtask

    task automatic check(input string tag);
        logic [7:0] exp_tot;
        exp_tot = 8'(m_tot);
        vectors++;
        assert (d === m_d) else begin
            miscompares++;
            $error("FAIL %s d: observed %b expected %b at t=%0t", tag, d, m_d, $time);
        end
        vectors++;
        assert (dut.tot === exp_tot) else begin
            miscompares++;
            $error("FAIL %s tot: observed %0d expected %0d at t=%0t", tag, dut.tot, exp_tot, $time);
        end
    endtask

    // Apply inputs, clock one edge, then compare just after the edge.
    task automatic step(input logic ci, input logic [7:0] ai, input logic ri, input string tag);
        c   = ci;
        a   = ai;
        rst = ri;
        @(posedge clk);
        model_edge();
        if (m_d) vends++;
        #1;
        check(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, tag);
    endtask

    task automatic coin(input logic [7:0] val, input string tag);
        step(1'b1, val, 1'b0, tag);
        step(1'b0, 8'd0, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 8'd0, 1'b1, tag);
        step(1'b0, 8'd0, 1'b0, tag);
        step(1'b0, 8'd0, 1'b0, tag);
    endtask

    initial begin
        int v0;
        @(negedge clk);

        // Reset state with price 60.
        s = 8'd60;
        do_reset("reset");
        idle(2, "reset_idle");

        // Normal vend: 25+10+5 stays below 60, the next 25 crosses it.
        coin(8'd25, "norm");
        coin(8'd10, "norm");
        coin(8'd5,  "norm");
        idle(3, "norm_below");
        v0 = vends;
        coin(8'd25, "norm_vend");
        idle(4, "norm_after");
        vectors++;
        assert (vends - v0 == 1) else begin
            miscompares++;
            $error("FAIL norm_count vends: observed %0d expected 1", vends - v0);
        end

        // Exact price, then a long quiet stretch.
        s = 8'd60;
        coin(8'd25, "exact");
        coin(8'd25, "exact");
        coin(8'd10, "exact");
        idle(24, "exact_quiet");

        // Saturation at 255 with the maximum price.
        s = 8'd255;
        coin(8'd200, "sat");
        coin(8'd100, "sat");
        idle(5, "sat_after");

        // Zero price vends every third cycle.
        s = 8'd0;
        do_reset("zero_rst");
        idle(12, "zero_price");

        // Coin presented while dispensing is dropped.
        s = 8'd20;
        do_reset("disp_rst");
        coin(8'd20, "disp_coin");
        step(1'b0, 8'd0, 1'b0, "disp_coin");
        step(1'b1, 8'd50, 1'b0, "disp_ignored");
        idle(4, "disp_after");

        // Held strobe: one coin every two cycles.
        s = 8'd200;
        for (int i = 0; i < 4; i++) step(1'b1, 8'd10, 1'b0, "held");
        idle(2, "held_after");

        // Price lowered below the running total.
        s = 8'd60;
        do_reset("lower_rst");
        coin(8'd40, "lower");
        idle(2, "lower_wait");
        s = 8'd30;
        idle(4, "lower_vend");

        // Reset during ADD and during DISP.
        s = 8'd10;
        do_reset("mid_rst");
        step(1'b1, 8'd50, 1'b0, "mid_coin");
        step(1'b0, 8'd0, 1'b1, "mid_add_rst");
        s = 8'd200;
        idle(3, "mid_add_after");
        s = 8'd10;
        coin(8'd50, "mid_coin2");
        step(1'b0, 8'd0, 1'b0, "mid_disp");
        step(1'b0, 8'd0, 1'b1, "mid_disp_rst");
        s = 8'd200;
        idle(3, "mid_disp_after");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) s = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) s = 8'($urandom_range(0, 60));
            step(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 120)),
                 ($urandom_range(0, 99) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
